enet_tx_frame_reader: RTL and testbench

Transmit-side frame reader for the 10/100 MAC. It drains one frame, previously written into the shared 32-bit-wide packet RAM by the host side, out of the RAM's second port. It serialises that frame as a byte stream with valid/ready handshake toward the TX MAC datapath. It hides the RAM's one-cycle registered read latency with a one-word prefetch, so steady-state throughput is one byte per cycle.

---
 rtl/enet_pkg.sv | 19 +
 rtl/enet_tx_frame_reader.sv | 148 ++++++++++++++
 tb/tb_enet_tx_frame_reader.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/enet_pkg.sv
// Shared definitions for the Ethernet TX frame reader: FSM states, byte-lane
// selects and the largest frame the MAC is expected to hand over.
package enet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

    localparam int MAX_FRAME_LEN = 1536;

endpackage

// File: rtl/enet_tx_frame_reader.sv
// Drains one frame from the 32-bit packet RAM read port and emits it as a
// little-endian byte stream, hiding the RAM read latency with a one-word prefetch.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start_i; len 0 only pulses done_o
//   ST_FETCH  | first word address presented, data not yet back
//   ST_LOAD   | capture first word, issue next word address
//   ST_STREAM | bytes offered to the MAC, next word prefetched
module enet_tx_frame_reader
    import enet_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int LEN_W  = 11
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [31:0]       ram_data_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_last_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    state_t            state_q, state_d;
    logic [31:0]       cur_word_q;
    logic [31:0]       pf_word_q;
    logic [31:0]       pf_src;
    logic [1:0]        lane_q;
    logic [LEN_W-1:0]  rem_cnt_q;
    logic [LEN_W-2:0]  words_left_q;
    logic [LEN_W:0]    len_rnd;
    logic              rd_issue_q;
    logic              rd_data_q;
    logic              done_q;
    logic              hs;
    logic              last_hs;
    logic              word_end;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            LANE_B0: lane_byte = w[7:0];
            LANE_B1: lane_byte = w[15:8];
            LANE_B2: lane_byte = w[23:16];
            default: lane_byte = w[31:24];
        endcase
    endfunction

    assign len_rnd    = {1'b0, len_i} + (LEN_W+1)'(3);
    assign tx_valid_o = (state_q == ST_STREAM);
    assign tx_data_o  = lane_byte(cur_word_q, lane_q);
    assign tx_last_o  = tx_valid_o && (rem_cnt_q == LEN_W'(1));
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    // A prefetch landing on the very cycle its predecessor word ends is forwarded.
    assign pf_src     = rd_data_q ? ram_data_i : pf_word_q;

    always_comb begin
        hs       = tx_valid_o && tx_ready_i;
        last_hs  = hs && (rem_cnt_q == LEN_W'(1));
        word_end = hs && !last_hs && (lane_q == LANE_B3);
        state_d  = state_q;
        case (state_q)
            ST_IDLE:   if (start_i && (len_i != '0)) state_d = ST_FETCH;
            ST_FETCH:  state_d = abort_i ? ST_IDLE : ST_LOAD;
            ST_LOAD:   state_d = abort_i ? ST_IDLE : ST_STREAM;
            ST_STREAM: if (abort_i || last_hs) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ram_addr_o   <= '0;
            cur_word_q   <= '0;
            pf_word_q    <= '0;
            lane_q       <= LANE_B0;
            rem_cnt_q    <= '0;
            words_left_q <= '0;
            rd_issue_q   <= 1'b0;
            rd_data_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_issue_q <= 1'b0;
            rd_data_q  <= rd_issue_q;
            if ((state_q != ST_IDLE) && abort_i) begin
                rem_cnt_q    <= '0;
                words_left_q <= '0;
                rd_data_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            if (len_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                ram_addr_o   <= base_addr_i;
                                rem_cnt_q    <= len_i;
                                words_left_q <= len_rnd[LEN_W:2] - (LEN_W-1)'(1);
                                lane_q       <= LANE_B0;
                            end
                        end
                    end
                    ST_LOAD: begin
                        cur_word_q <= ram_data_i;
                        lane_q     <= LANE_B0;
                        if (words_left_q != '0) begin
                            ram_addr_o   <= ram_addr_o + ADDR_W'(1);
                            words_left_q <= words_left_q - (LEN_W-1)'(1);
                            rd_issue_q   <= 1'b1;
                        end
                    end
                    ST_STREAM: begin
                        if (rd_data_q) pf_word_q <= ram_data_i;
                        if (hs) begin
                            rem_cnt_q <= rem_cnt_q - LEN_W'(1);
                            lane_q    <= lane_q + 2'd1;
                            if (last_hs) done_q <= 1'b1;
                        end
                        if (word_end) begin
                            cur_word_q <= pf_src;
                            if (words_left_q != '0) begin
                                ram_addr_o   <= ram_addr_o + ADDR_W'(1);
                                words_left_q <= words_left_q - (LEN_W-1)'(1);
                                rd_issue_q   <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enet_tx_frame_reader.sv
// Randomised bench for enet_tx_frame_reader: a queue-based frame model built
// from RAM contents is checked against the DUT every cycle.
module tb_enet_tx_frame_reader;
    import enet_pkg::*;

    localparam int ADDR_W = 9;
    localparam int LEN_W  = 11;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic              abort_i = 1'b0;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_data_i;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_last_o;
    logic              tx_ready_i = 1'b1;
    logic              busy_o;
    logic              done_o;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    int                cyc = 0;
    int                vectors = 0;
    int                miscompares = 0;
    bit                rand_ready = 1'b0;

    // model state
    bit                m_busy = 1'b0;
    bit                m_done = 1'b0;
    int                m_wait = 0;
    logic [7:0]        m_q[$];
    logic [ADDR_W-1:0] m_aq[$];
    logic [7:0]        obs_q[$];
    logic [ADDR_W-1:0] obs_aq[$];
    logic [7:0]        ref_q[$];
    logic [ADDR_W-1:0] prev_addr = '0;
    int                first_valid_cyc = -1;
    int                done_cyc = -1;
    int                done_cnt = 0;
    int                start_t = 0;
    logic [7:0]        exp_basic [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0]        exp_short [4] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};

    enet_tx_frame_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .ram_addr_o  (ram_addr_o),
        .ram_data_i  (ram_data_i),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_last_o   (tx_last_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc        <= cyc + 1;
        ram_data_i <= mem[ram_addr_o];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: checks the current cycle, then advances the model
    // with the inputs the DUT will sample at the coming edge.
    initial begin
        bit         m_valid;
        logic [31:0] w;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                chk("rst_busy", busy_o, 0);
                chk("rst_valid", tx_valid_o, 0);
                chk("rst_data", tx_data_o, 0);
                chk("rst_last", tx_last_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_addr", ram_addr_o, 0);
                m_busy = 0; m_done = 0; m_wait = 0;
                m_q.delete(); m_aq.delete();
                prev_addr = ram_addr_o;
                continue;
            end
            m_valid = m_busy && (m_wait == 0);
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done);
            chk("valid", tx_valid_o, m_valid);
            if (m_valid) begin
                chk("data", tx_data_o, m_q[0]);
                chk("last", tx_last_o, m_q.size() == 1);
            end
            if (tx_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done_o) begin done_cyc = cyc; done_cnt++; end
            if (m_busy && (m_wait == 2 || ram_addr_o != prev_addr)) begin
                if (m_aq.size() == 0) chk("extra_read_addr", ram_addr_o, prev_addr);
                else begin
                    obs_aq.push_back(ram_addr_o);
                    chk("read_addr", ram_addr_o, m_aq.pop_front());
                end
            end else if (!m_busy) begin
                chk("idle_addr_hold", ram_addr_o, prev_addr);
            end
            prev_addr = ram_addr_o;

            m_done = 0;
            if (m_busy) begin
                if (abort_i) begin
                    m_busy = 0; m_q.delete(); m_aq.delete();
                end else if (m_wait > 0) begin
                    m_wait--;
                end else if (tx_ready_i) begin
                    obs_q.push_back(tx_data_o);
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        chk("missing_reads", m_aq.size(), 0);
                        m_busy = 0; m_done = 1;
                    end
                end
            end else if (start_i) begin
                if (len_i == '0) m_done = 1;
                else begin
                    for (int i = 0; i < int'(len_i); i++) begin
                        w = mem[base_addr_i + ADDR_W'(i / 4)];
                        m_q.push_back(w[8*(i%4) +: 8]);
                    end
                    for (int k = 0; k < (int'(len_i) + 3) / 4; k++)
                        m_aq.push_back(base_addr_i + ADDR_W'(k));
                    m_busy = 1; m_wait = 2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        obs_q.delete(); obs_aq.delete();
        first_valid_cyc = -1; done_cyc = -1; done_cnt = 0;
        start_i = 1'b1; base_addr_i = b; len_i = l;
        start_t = cyc + 1;
        tick();
        start_i = 1'b0;
        base_addr_i = ADDR_W'($urandom);
        len_i = LEN_W'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!m_busy) return;
            tick();
        end
        chk("idle_timeout", busy_o, 0);
    endtask

    task automatic stream_random(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        start_frame(b, l);
        for (int i = 0; i < 4000 && m_busy; i++) begin
            if (m_q.size() > 2 && $urandom_range(0, 15) == 0) begin
                start_i = 1'b1; len_i = LEN_W'($urandom_range(1, 50));
            end else start_i = 1'b0;
            abort_i = ($urandom_range(0, 63) == 0);
            tick();
        end
        start_i = 1'b0; abort_i = 1'b0;
        wait_idle(10);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        mem[9'h010] = 32'h44332211;
        mem[9'h011] = 32'h66556655;
        mem[9'h040] = 32'hDEADBEA5;
        mem[9'h060] = 32'h0A0B0C0D;
        repeat (3) tick();
        rst_i = 1'b1;
        tick();

        // basic frame
        rand_ready = 0;
        start_frame(9'h010, 6);
        wait_idle(50); tick(); tick();
        chk("basic_count", obs_q.size(), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) chk("basic_byte", obs_q[i], exp_basic[i]);
        chk("basic_first_valid_offset", first_valid_cyc - start_t, 2);
        chk("basic_done_offset", done_cyc - start_t, 8);
        chk("basic_reads", obs_aq.size(), 2);
        if (obs_aq.size() == 2) begin
            chk("basic_addr0", obs_aq[0], 9'h010);
            chk("basic_addr1", obs_aq[1], 9'h011);
        end

        // zero and single-byte lengths
        start_frame(9'h0AA, 0);
        tick(); tick();
        chk("len0_done_offset", done_cyc - start_t, 0);
        chk("len0_done_pulses", done_cnt, 1);
        chk("len0_bytes", obs_q.size(), 0);
        start_frame(9'h040, 1);
        wait_idle(20); tick(); tick();
        chk("len1_count", obs_q.size(), 1);
        if (obs_q.size() == 1) chk("len1_byte", obs_q[0], 8'hA5);
        chk("len1_done_offset", done_cyc - start_t, 3);

        // backpressure: same frame with and without stalls
        start_frame(9'h0A0, 9);
        wait_idle(60);
        ref_q = obs_q;
        rand_ready = 1;
        tick();
        start_frame(9'h0A0, 9);
        wait_idle(400); tick();
        chk("bp_count", obs_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++) chk("bp_byte", obs_q[i], ref_q[i]);
        chk("bp_reads", obs_aq.size(), 3);

        // wrap past top of buffer
        rand_ready = 0;
        tick();
        start_frame(9'h1FF, 8);
        wait_idle(40); tick();
        chk("wrap_count", obs_q.size(), 8);
        chk("wrap_reads", obs_aq.size(), 2);
        if (obs_aq.size() == 2) begin
            chk("wrap_addr0", obs_aq[0], 9'h1FF);
            chk("wrap_addr1", obs_aq[1], 9'h000);
        end

        // abort after three bytes, then back-to-back start
        start_frame(9'h080, 64);
        for (int i = 0; i < 40 && obs_q.size() < 3; i++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_valid", tx_valid_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_bytes", obs_q.size(), 3);
        chk("abort_no_done", done_cnt, 0);
        start_frame(9'h100, 12);
        wait_idle(40); tick();
        chk("after_abort_count", obs_q.size(), 12);
        chk("after_abort_done", done_cnt, 1);

        // random frames, back-to-back, random stalls, stray starts and aborts
        for (int f = 0; f < 24; f++) begin
            rand_ready = f[0];
            stream_random(ADDR_W'($urandom), LEN_W'($urandom_range(1, MAX_FRAME_LEN / 12)));
        end

        // asynchronous reset mid-frame
        rand_ready = 0;
        tick();
        start_frame(9'h050, 40);
        repeat (10) tick();
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        #1;
        chk("rstmid_busy", busy_o, 0);
        chk("rstmid_valid", tx_valid_o, 0);
        chk("rstmid_data", tx_data_o, 0);
        chk("rstmid_last", tx_last_o, 0);
        chk("rstmid_done", done_o, 0);
        chk("rstmid_addr", ram_addr_o, 0);
        tick();
        rst_i = 1'b1;
        tick();
        start_frame(9'h060, 4);
        wait_idle(30); tick();
        chk("post_rst_count", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++) chk("post_rst_byte", obs_q[i], exp_short[i]);

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
